control_alarma: RTL and testbench
=================================

Name: control_alarma

Overview:
- Alarm sequencer for the clock design.
- Owns the stored alarm time, loaded from the `setare` block via `load_alarma`. Compares it against the running time and drives the ring output through a ring / snooze / stop state machine with auto-timeout.
- Sits between `setare` (setting source), the minute/hour counter (time source, minute tick) and the buzzer/display.

Parameters:
- RING_MIN, 5, minutes the alarm rings before auto-stop (1..15)
- SNOOZE_MIN, 9, minutes of snooze before re-ring (1..15)
- MAX_SNOOZE, 3, snoozes allowed per alarm event; further snooze presses are ignored

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- tick_min  in  1  one-cycle pulse at each minute rollover of the time counter
- timp_ore  in  5  current hour, 0..23
- timp_minute  in  6  current minute, 0..59
- ore  in  5  hour value from `setare`
- minute  in  6  minute value from `setare`
- load_alarma  in  1  one-cycle load strobe from `setare`
- load_timp  in  1  time-load strobe from `setare`; inhibits match for that cycle
- alarma_en  in  1  level, alarm enabled
- semnal_stop  in  1  stop button, pulse, synchronous
- semnal_snooze  in  1  snooze button, pulse, synchronous
- alarma_ore  out  5  stored alarm hour
- alarma_minute  out  6  stored alarm minute
- suna  out  1  buzzer drive, high in SUNA
- stare  out  2  state code: 00 OPRIT, 01 ARMAT, 10 SUNA, 11 AMANAT
- err_load  out  1  one-cycle pulse, rejected alarm load

Behaviour:
- Reset (reset = 0, asynchronous) sets:
  - state = OPRIT, alarma_ore = 0, alarma_minute = 0, suna = 0, err_load = 0
  - ring_cnt = 0, snooze_cnt = 0, nr_snooze = 0, match_q = 0
- Outputs are registered. suna and stare reflect the state one cycle after the causing input.
- Alarm load:
  - load_alarma with ore <= 23 and minute <= 59: capture both next edge.
  - Otherwise: keep old values and pulse err_load for 1 cycle.
  - A valid load while in SUNA or AMANAT forces ARMAT (alarma_en = 1) or OPRIT (alarma_en = 0), and clears nr_snooze.
- Match:
  - potrivire = (timp_ore == alarma_ore) && (timp_minute == alarma_minute) && !load_timp. match_q is registered every cycle.
  - Fire event = potrivire && !match_q, i.e. a rising edge only. Holding at the matching minute never re-fires.
  - A load_alarma in the same cycle as a match wins; match is evaluated against the new value from the next cycle.
- State machine, priority order per cycle: alarma_en = 0 > valid load_alarma > semnal_stop > semnal_snooze > counter expiry.
- OPRIT:
  - alarma_en = 1 -> ARMAT next cycle.
  - The fire event is ignored; match_q still tracks.
- ARMAT:
  - Fire event -> SUNA, ring_cnt = RING_MIN, nr_snooze = 0.
- SUNA:
  - tick_min decrements ring_cnt. tick_min with ring_cnt == 1 -> ARMAT (auto-stop), nr_snooze = 0.
  - semnal_stop -> ARMAT, nr_snooze = 0.
  - semnal_snooze with nr_snooze < MAX_SNOOZE -> AMANAT, snooze_cnt = SNOOZE_MIN, nr_snooze += 1.
  - semnal_snooze with nr_snooze == MAX_SNOOZE is ignored; state stays SUNA.
- AMANAT:
  - tick_min decrements snooze_cnt. tick_min with snooze_cnt == 1 -> SUNA, ring_cnt = RING_MIN.
  - semnal_stop -> ARMAT, nr_snooze = 0.
  - semnal_snooze is ignored.
- Simultaneous events:
  - stop + snooze: stop wins.
  - stop + tick_min: stop wins, counters are not decremented.
  - Fire event while in SUNA/AMANAT: ignored.
- alarma_en falling in any state -> OPRIT next cycle, suna = 0, nr_snooze = 0.
- Counter widths: 4 bits for ring_cnt and snooze_cnt, 2 bits minimum for nr_snooze. No wrap: counters only decrement when nonzero.
- Reset mid-ring: suna drops asynchronously; the stored alarm returns to 00:00.

Test Plan:
- Reset with time 00:00, alarma_en = 1 -> stare = 00 during reset; ARMAT after; no ring, because match_q is low but state was OPRIT at the edge of the first match cycle. Verify suna = 0.
- Load alarm 07:30, advance time 07:29 -> 07:30 -> suna = 1 one cycle after match. Apply 5 tick_min -> suna = 0, stare = 01. Remain at 07:30 -> no re-fire.
- Ringing at 07:30, snooze -> stare = 11. 9 tick_min -> stare = 10. Repeat to 3 snoozes; 4th snooze ignored, suna stays 1; stop -> stare = 01.
- load_alarma with ore = 24, minute = 10 -> err_load pulse 1 cycle, alarma_ore/minute unchanged. Then 23:59 loads correctly.
- stop and snooze in the same cycle while SUNA -> stare = 01. stop and tick_min together -> ring_cnt unchanged, stare = 01.
- alarma_en dropped while AMANAT -> stare = 00, suna = 0. Assert reset mid-SUNA -> suna = 0 immediately without a clock edge.

Source files
------------

// File: rtl/control_alarma.sv
// Alarm sequencer: stores the alarm time and runs the ring / snooze / stop
// state machine against the running time.
module control_alarma #(
    parameter int RING_MIN   = 5,
    parameter int SNOOZE_MIN = 9,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_min,
    input  logic [4:0] timp_ore,
    input  logic [5:0] timp_minute,
    input  logic [4:0] ore,
    input  logic [5:0] minute,
    input  logic       load_alarma,
    input  logic       load_timp,
    input  logic       alarma_en,
    input  logic       semnal_stop,
    input  logic       semnal_snooze,
    output logic [4:0] alarma_ore,
    output logic [5:0] alarma_minute,
    output logic       suna,
    output logic [1:0] stare,
    output logic       err_load
);

    localparam int NW = ($clog2(MAX_SNOOZE + 1) < 2) ? 2 : $clog2(MAX_SNOOZE + 1);

    typedef enum logic [1:0] {
        OPRIT  = 2'b00,
        ARMAT  = 2'b01,
        SUNA   = 2'b10,
        AMANAT = 2'b11
    } stare_t;

    stare_t        stare_q, stare_d;
    logic [3:0]    ring_cnt, ring_d;
    logic [3:0]    snooze_cnt, snooze_d;
    logic [NW-1:0] nr_snooze, nr_d;
    logic          match_q;
    logic          valid_load;
    logic          potrivire;
    logic          fire;

    assign valid_load = load_alarma && (ore <= 5'd23) && (minute <= 6'd59);
    assign potrivire  = (timp_ore == alarma_ore) && (timp_minute == alarma_minute) && !load_timp;
    // A valid load in the same cycle takes precedence over a match on the old value.
    assign fire       = potrivire && !match_q && !valid_load;

    assign stare = stare_q;
    assign suna  = (stare_q == SUNA);

    always_comb begin
        stare_d  = stare_q;
        ring_d   = ring_cnt;
        snooze_d = snooze_cnt;
        nr_d     = nr_snooze;
        if (!alarma_en) begin
            stare_d = OPRIT;
            nr_d    = '0;
        end else if (valid_load && (stare_q == SUNA || stare_q == AMANAT)) begin
            stare_d = ARMAT;
            nr_d    = '0;
        end else begin
            case (stare_q)
                OPRIT: stare_d = ARMAT;
                ARMAT: begin
                    if (fire) begin
                        stare_d = SUNA;
                        ring_d  = 4'(RING_MIN);
                        nr_d    = '0;
                    end
                end
                SUNA: begin
                    if (semnal_stop) begin
                        stare_d = ARMAT;
                        nr_d    = '0;
                    end else if (semnal_snooze && (nr_snooze < NW'(MAX_SNOOZE))) begin
                        stare_d  = AMANAT;
                        snooze_d = 4'(SNOOZE_MIN);
                        nr_d     = nr_snooze + NW'(1);
                    end else if (tick_min && (ring_cnt != 4'd0)) begin
                        // An exhausted snooze press falls through so the minute still counts.
                        ring_d = ring_cnt - 4'd1;
                        if (ring_cnt == 4'd1) begin
                            stare_d = ARMAT;
                            nr_d    = '0;
                        end
                    end
                end
                AMANAT: begin
                    if (semnal_stop) begin
                        stare_d = ARMAT;
                        nr_d    = '0;
                    end else if (tick_min && (snooze_cnt != 4'd0)) begin
                        snooze_d = snooze_cnt - 4'd1;
                        if (snooze_cnt == 4'd1) begin
                            stare_d = SUNA;
                            ring_d  = 4'(RING_MIN);
                        end
                    end
                end
                default: stare_d = OPRIT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stare_q       <= OPRIT;
            ring_cnt      <= '0;
            snooze_cnt    <= '0;
            nr_snooze     <= '0;
            match_q       <= 1'b0;
            alarma_ore    <= '0;
            alarma_minute <= '0;
            err_load      <= 1'b0;
        end else begin
            stare_q    <= stare_d;
            ring_cnt   <= ring_d;
            snooze_cnt <= snooze_d;
            nr_snooze  <= nr_d;
            match_q    <= potrivire;
            err_load   <= load_alarma && !valid_load;
            if (valid_load) begin
                alarma_ore    <= ore;
                alarma_minute <= minute;
            end
        end
    end

endmodule

// File: tb/tb_control_alarma.sv
// Randomized plus directed bench for control_alarma against a minute-based
// behavioural model of the alarm.
module tb_control_alarma;

    localparam int RING_MIN   = 5;
    localparam int SNOOZE_MIN = 9;
    localparam int MAX_SNOOZE = 3;

    logic       clock;
    logic       reset;
    logic       tick_min;
    logic [4:0] timp_ore;
    logic [5:0] timp_minute;
    logic [4:0] ore;
    logic [5:0] minute;
    logic       load_alarma;
    logic       load_timp;
    logic       alarma_en;
    logic       semnal_stop;
    logic       semnal_snooze;
    logic [4:0] alarma_ore;
    logic [5:0] alarma_minute;
    logic       suna;
    logic [1:0] stare;
    logic       err_load;

    control_alarma #(
        .RING_MIN  (RING_MIN),
        .SNOOZE_MIN(SNOOZE_MIN),
        .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick_min     (tick_min),
        .timp_ore     (timp_ore),
        .timp_minute  (timp_minute),
        .ore          (ore),
        .minute       (minute),
        .load_alarma  (load_alarma),
        .load_timp    (load_timp),
        .alarma_en    (alarma_en),
        .semnal_stop  (semnal_stop),
        .semnal_snooze(semnal_snooze),
        .alarma_ore   (alarma_ore),
        .alarma_minute(alarma_minute),
        .suna         (suna),
        .stare        (stare),
        .err_load     (err_load)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scoreboard
    int n_checks = 0;
    int n_pass   = 0;
    logic [14:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // behavioural model: alarm as minute-of-day, modes coded as the visible state code
    localparam int M_OFF = 0, M_ARM = 1, M_RING = 2, M_SNZ = 3;
    int m_mode, m_alarm, m_ring_left, m_snz_left, m_used;
    bit m_match_prev, m_err;

    task automatic model_reset();
        m_mode = M_OFF; m_alarm = 0; m_ring_left = 0; m_snz_left = 0;
        m_used = 0; m_match_prev = 0; m_err = 0;
    endtask

    task automatic model_step();
        int  now_t, req_o, req_m;
        bit  match_now, valid, fire;
        now_t     = int'(timp_ore) * 60 + int'(timp_minute);
        req_o     = int'(ore);
        req_m     = int'(minute);
        match_now = (now_t == m_alarm) && !load_timp;
        valid     = load_alarma && req_o <= 23 && req_m <= 59;
        fire      = match_now && !m_match_prev && !valid;
        m_err     = load_alarma && !valid;
        if (!alarma_en) begin
            m_mode = M_OFF; m_used = 0;
        end else if (valid && (m_mode == M_RING || m_mode == M_SNZ)) begin
            m_mode = M_ARM; m_used = 0;
        end else if (m_mode == M_OFF) begin
            m_mode = M_ARM;
        end else if (m_mode == M_ARM) begin
            if (fire) begin m_mode = M_RING; m_ring_left = RING_MIN; m_used = 0; end
        end else if (m_mode == M_RING) begin
            if (semnal_stop) begin
                m_mode = M_ARM; m_used = 0;
            end else if (semnal_snooze && m_used < MAX_SNOOZE) begin
                m_mode = M_SNZ; m_snz_left = SNOOZE_MIN; m_used++;
            end else if (tick_min && m_ring_left > 0) begin
                m_ring_left--;
                if (m_ring_left == 0) begin m_mode = M_ARM; m_used = 0; end
            end
        end else begin
            if (semnal_stop) begin
                m_mode = M_ARM; m_used = 0;
            end else if (tick_min && m_snz_left > 0) begin
                m_snz_left--;
                if (m_snz_left == 0) begin m_mode = M_RING; m_ring_left = RING_MIN; end
            end
        end
        if (valid) m_alarm = req_o * 60 + req_m;
        m_match_prev = match_now;
        exp_q.push_back({2'(m_mode), m_mode == M_RING, m_err, 5'(m_alarm / 60), 6'(m_alarm % 60)});
    endtask

    task automatic compare_outputs();
        logic [14:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("stare", 32'(stare), 32'(e[14:13]));
        check("suna", 32'(suna), 32'(e[12]));
        check("err_load", 32'(err_load), 32'(e[11]));
        check("alarma_ore", 32'(alarma_ore), 32'(e[10:6]));
        check("alarma_minute", 32'(alarma_minute), 32'(e[5:0]));
    endtask

    // drivers
    int cur_en, cur_h, cur_m;

    task automatic apply(input logic ld, input int o, input int mi, input logic lt,
                         input logic st, input logic sz, input logic tk);
        alarma_en     = cur_en[0];
        timp_ore      = 5'(cur_h);
        timp_minute   = 6'(cur_m);
        load_alarma   = ld;
        ore           = 5'(o);
        minute        = 6'(mi);
        load_timp     = lt;
        semnal_stop   = st;
        semnal_snooze = sz;
        tick_min      = tk;
        model_step();
        @(posedge clock);
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) apply(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) apply(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic ring_at_0730();
        cur_h = 7; cur_m = 31; idle(1);
        cur_m = 30; idle(1);
        check("ring_start", 32'(stare), 32'd2);
    endtask

    initial begin
        reset = 1'b0;
        cur_en = 1; cur_h = 0; cur_m = 0;
        alarma_en = 1; timp_ore = 0; timp_minute = 0; load_alarma = 0; ore = 0; minute = 0;
        load_timp = 0; semnal_stop = 0; semnal_snooze = 0; tick_min = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset_stare", 32'(stare), 0);
        check("reset_suna", 32'(suna), 0);
        check("reset_alarm", {alarma_ore, alarma_minute}, 0);
        check("reset_err", 32'(err_load), 0);
        reset = 1'b1;

        // time 00:00 matches the reset alarm but the machine was still OPRIT
        idle(4);
        check("no_ring_after_reset", 32'(suna), 0);

        // load 07:30, ring, auto-stop, no re-fire while holding
        cur_h = 7; cur_m = 29;
        apply(1, 7, 30, 0, 0, 0, 0);
        idle(2);
        cur_m = 30; idle(1);
        check("ring_on_match", 32'(suna), 1);
        ticks(RING_MIN);
        check("auto_stop", 32'(stare), 32'd1);
        idle(3);
        check("no_refire", 32'(suna), 0);

        // snooze cycles, exhausted snooze, stop
        ring_at_0730();
        for (int i = 0; i < MAX_SNOOZE; i++) begin
            apply(0, 0, 0, 0, 0, 1, 0);
            check("snoozed", 32'(stare), 32'd3);
            ticks(SNOOZE_MIN);
            check("re_ring", 32'(stare), 32'd2);
        end
        apply(0, 0, 0, 0, 0, 1, 0);
        check("snooze_exhausted", 32'(suna), 1);
        apply(0, 0, 0, 0, 1, 0, 0);
        check("stopped", 32'(stare), 32'd1);

        // rejected and accepted loads
        apply(1, 24, 10, 0, 0, 0, 0);
        check("err_pulse", 32'(err_load), 1);
        idle(1);
        check("err_one_cycle", 32'(err_load), 0);
        apply(1, 23, 59, 0, 0, 0, 0);
        check("load_2359", {alarma_ore, alarma_minute}, {5'd23, 6'd59});
        apply(1, 7, 30, 0, 0, 0, 0);

        // simultaneous events
        ring_at_0730();
        apply(0, 0, 0, 0, 1, 1, 0);
        check("stop_beats_snooze", 32'(stare), 32'd1);
        ring_at_0730();
        apply(0, 0, 0, 0, 1, 0, 1);
        check("stop_beats_tick", 32'(stare), 32'd1);

        // enable drop while snoozing
        ring_at_0730();
        apply(0, 0, 0, 0, 0, 1, 0);
        cur_en = 0; idle(1);
        check("en_drop", 32'(stare), 0);
        cur_en = 1; idle(2);

        // asynchronous reset while ringing
        ring_at_0730();
        reset = 1'b0;
        #2;
        check("async_suna", 32'(suna), 0);
        check("async_alarm", {alarma_ore, alarma_minute}, 0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        exp_q.delete();

        // randomized phase
        for (int c = 0; c < 4000; c++) begin
            logic ld, lt, st, sz, tk;
            int o, mi;
            cur_en = ($urandom_range(0, 59) != 0) ? 1 : 0;
            if ($urandom_range(0, 3) == 0) begin
                cur_h = $urandom_range(6, 8);
                cur_m = $urandom_range(28, 32);
            end
            ld = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 4) == 0) begin
                o = $urandom_range(0, 31); mi = $urandom_range(0, 63);
            end else begin
                o = $urandom_range(6, 8); mi = $urandom_range(28, 32);
            end
            lt = ($urandom_range(0, 14) == 0);
            st = ($urandom_range(0, 24) == 0);
            sz = ($urandom_range(0, 7) == 0);
            tk = ($urandom_range(0, 2) == 0);
            apply(ld, o, mi, lt, st, sz, tk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
